// File: rtl/bs_rx_pkg.sv
// Shared receive-side types: the rx state encoding (also read back over AXI
// status) and a counter width helper.
package bs_rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_ARMED = 2'd1,
    RX_RUN   = 2'd2
  } rx_state_e;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int unsigned ctr_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pcode_correlator.sv
// Despreading pipeline. S0 registers the sample and drives the ROM address,
// S1 waits for the ROM, S2 applies the chip sign and integrates the epoch.
// A tag supplied with each sample travels with it and is reported together
// with epoch_done so the caller knows which epoch/bit just finished.
module pcode_correlator
  import bs_rx_pkg::*;
#(
  parameter int unsigned PCODE_LEN = 40920,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned TAG_W     = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic                        accept_i,
  input  logic signed [11:0]          sample_i,
  input  logic [TAG_W-1:0]            tag_i,
  input  logic                        pcode_bit_i,
  output logic [15:0]                 pcode_addr_o,
  output logic                        chip_zero_o,
  output logic                        chip_last_o,
  output logic                        epoch_done_o,
  output logic signed [ACC_WIDTH-1:0] epoch_sum_o,
  output logic [TAG_W-1:0]            epoch_tag_o
);

  localparam int unsigned     CW        = ctr_width(PCODE_LEN);
  localparam logic [CW-1:0]   CHIP_LAST = CW'(PCODE_LEN - 1);

  logic [CW-1:0]               chip_ctr_q, chip_cur, chip_next;
  logic [15:0]                 pcode_addr_q;
  logic                        s1_valid_q, s1_last_q, s2_valid_q, s2_last_q;
  logic signed [11:0]          s1_sample_q, s2_sample_q;
  logic [TAG_W-1:0]            s1_tag_q, s2_tag_q, done_tag_q;
  logic signed [ACC_WIDTH-1:0] epoch_acc_q, sample_ext, product;
  logic                        restart_q, done_q;

  // A flushed counter counts as zero so a sample accepted alongside the flush is chip 0.
  always_comb begin
    chip_cur   = flush_i ? '0 : chip_ctr_q;
    chip_next  = (chip_cur == CHIP_LAST) ? '0 : chip_cur + CW'(1);
    sample_ext = {{(ACC_WIDTH-12){s2_sample_q[11]}}, s2_sample_q};
    product    = pcode_bit_i ? sample_ext : -sample_ext;
  end

  assign chip_zero_o  = (chip_ctr_q == '0);
  assign chip_last_o  = (chip_cur == CHIP_LAST);
  assign pcode_addr_o = pcode_addr_q;
  assign epoch_done_o = done_q;
  assign epoch_sum_o  = epoch_acc_q;
  assign epoch_tag_o  = done_tag_q;

  // S0/S1 stages and chip counter; the address only moves on an accepted sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      chip_ctr_q   <= '0;
      pcode_addr_q <= '0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_sample_q  <= '0;
      s1_tag_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_last_q    <= 1'b0;
      s2_sample_q  <= '0;
      s2_tag_q     <= '0;
    end else begin
      if (accept_i) begin
        pcode_addr_q <= 16'(chip_cur);
        chip_ctr_q   <= chip_next;
        s1_sample_q  <= sample_i;
        s1_last_q    <= chip_last_o;
        s1_tag_q     <= tag_i;
      end else if (flush_i) begin
        chip_ctr_q <= '0;
      end
      s1_valid_q  <= accept_i;
      s2_valid_q  <= s1_valid_q && !flush_i;
      s2_sample_q <= s1_sample_q;
      s2_last_q   <= s1_last_q;
      s2_tag_q    <= s1_tag_q;
    end
  end

  // S2 integration; after an epoch's last chip the next product starts the new sum.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      epoch_acc_q <= '0;
      restart_q   <= 1'b0;
      done_q      <= 1'b0;
      done_tag_q  <= '0;
    end else if (s2_valid_q) begin
      epoch_acc_q <= (restart_q ? '0 : epoch_acc_q) + product;
      restart_q   <= s2_last_q;
      done_q      <= s2_last_q;
      done_tag_q  <= s2_tag_q;
    end else begin
      done_q <= 1'b0;
    end
  end

endmodule

// File: rtl/message_rx.sv
// Message receiver: despreads PPS-aligned I samples against the P-code,
// decides one bit per PCODE_REPEATS epochs and assembles MESSAGE_LEN-bit frames.
module message_rx
  import bs_rx_pkg::*;
#(
  parameter int unsigned PCODE_LEN     = 40920,
  parameter int unsigned PCODE_REPEATS = 10,
  parameter int unsigned MESSAGE_LEN   = 120,
  parameter int unsigned ACC_WIDTH     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_enable,
  input  logic                        pps_in,
  input  logic                        adc_valid,
  input  logic signed [11:0]          adc_data_i,
  output logic [15:0]                 pcode_addr,
  input  logic                        pcode_bit,
  output logic                        bit_valid,
  output logic                        bit_value,
  output logic signed [ACC_WIDTH-1:0] corr_value,
  output logic                        msg_valid,
  output logic [MESSAGE_LEN-1:0]      msg_data,
  output logic                        pps_misalign,
  output logic [1:0]                  rx_state
);

  if (12 + $clog2(PCODE_LEN * PCODE_REPEATS) + 1 > ACC_WIDTH) begin : g_acc_width_check
    $error("message_rx: ACC_WIDTH too narrow for PCODE_LEN*PCODE_REPEATS");
  end

  localparam int unsigned   EW      = ctr_width(PCODE_REPEATS);
  localparam int unsigned   BW      = ctr_width(MESSAGE_LEN);
  localparam logic [EW-1:0] EP_LAST = EW'(PCODE_REPEATS - 1);
  localparam logic [BW-1:0] BT_LAST = BW'(MESSAGE_LEN - 1);

  rx_state_e                   state_q, state_d;
  logic [EW-1:0]               epoch_ctr_q, epoch_cur, epoch_next;
  logic [BW-1:0]               bit_ctr_q, bit_cur, bit_next;
  logic signed [ACC_WIDTH-1:0] bit_acc_q, bit_total, corr_q, epoch_sum;
  logic [MESSAGE_LEN-1:0]      shift_q, shift_next, msg_q;
  logic [MESSAGE_LEN:0]        shift_cat;
  logic                        bit_valid_q, bit_value_q, msg_valid_q, misalign_q, rx_en_q;
  logic                        in_run, aligned, misalign_pps, flush, accept, decide, bit_new;
  logic                        chip_zero, chip_last, epoch_done;
  logic [1:0]                  tag, epoch_tag;

  // Next state; a low rx_enable wins from every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  state_d = RX_ARMED;
      RX_ARMED: if (pps_in) state_d = RX_RUN;
      RX_RUN:   state_d = RX_RUN;
      default:  state_d = RX_IDLE;
    endcase
    if (!rx_enable) state_d = RX_IDLE;
  end

  // Control decode, counter next values and the bit decision.
  always_comb begin
    in_run       = (state_q == RX_RUN) && rx_enable;
    aligned      = chip_zero && (epoch_ctr_q == '0) && (bit_ctr_q == '0);
    misalign_pps = in_run && pps_in && !aligned;
    flush        = !in_run || misalign_pps;
    accept       = adc_valid && rx_enable &&
                   ((state_q == RX_RUN) || ((state_q == RX_ARMED) && pps_in));
    epoch_cur    = flush ? '0 : epoch_ctr_q;
    bit_cur      = flush ? '0 : bit_ctr_q;
    epoch_next   = (epoch_cur == EP_LAST) ? '0 : epoch_cur + EW'(1);
    bit_next     = bit_cur;
    if (epoch_cur == EP_LAST) bit_next = (bit_cur == BT_LAST) ? '0 : bit_cur + BW'(1);
    tag          = {bit_cur == BT_LAST, epoch_cur == EP_LAST};
    decide       = in_run && !misalign_pps && epoch_done;
    bit_total    = bit_acc_q + epoch_sum;
    bit_new      = ~bit_total[ACC_WIDTH-1];
    shift_cat    = {shift_q, bit_new};
    shift_next   = shift_cat[MESSAGE_LEN-1:0];
  end

  pcode_correlator #(
    .PCODE_LEN (PCODE_LEN),
    .ACC_WIDTH (ACC_WIDTH),
    .TAG_W     (2)
  ) u_corr (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush),
    .accept_i     (accept),
    .sample_i     (adc_data_i),
    .tag_i        (tag),
    .pcode_bit_i  (pcode_bit),
    .pcode_addr_o (pcode_addr),
    .chip_zero_o  (chip_zero),
    .chip_last_o  (chip_last),
    .epoch_done_o (epoch_done),
    .epoch_sum_o  (epoch_sum),
    .epoch_tag_o  (epoch_tag)
  );

  // State register, epoch/bit counters (S0 timing) and sticky misalign flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      epoch_ctr_q <= '0;
      bit_ctr_q   <= '0;
      misalign_q  <= 1'b0;
      rx_en_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_en_q <= rx_enable;
      if (accept) begin
        epoch_ctr_q <= chip_last ? epoch_next : epoch_cur;
        bit_ctr_q   <= chip_last ? bit_next : bit_cur;
      end else if (flush) begin
        epoch_ctr_q <= '0;
        bit_ctr_q   <= '0;
      end
      if (rx_enable && !rx_en_q) misalign_q <= 1'b0;
      else if (misalign_pps)     misalign_q <= 1'b1;
    end
  end

  // Bit integration, decision and message assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_acc_q   <= '0;
      shift_q     <= '0;
      corr_q      <= '0;
      bit_value_q <= 1'b0;
      bit_valid_q <= 1'b0;
      msg_q       <= '0;
      msg_valid_q <= 1'b0;
    end else begin
      bit_valid_q <= 1'b0;
      msg_valid_q <= 1'b0;
      if (flush) begin
        bit_acc_q <= '0;
        shift_q   <= '0;
      end else if (decide) begin
        if (epoch_tag[0]) begin
          corr_q      <= bit_total;
          bit_value_q <= bit_new;
          bit_valid_q <= 1'b1;
          bit_acc_q   <= '0;
          if (epoch_tag[1]) begin
            msg_q       <= shift_next;
            msg_valid_q <= 1'b1;
            shift_q     <= '0;
          end else begin
            shift_q <= shift_next;
          end
        end else begin
          bit_acc_q <= bit_total;
        end
      end
    end
  end

  assign bit_valid    = bit_valid_q;
  assign bit_value    = bit_value_q;
  assign corr_value   = corr_q;
  assign msg_valid    = msg_valid_q;
  assign msg_data     = msg_q;
  assign pps_misalign = misalign_q;
  assign rx_state     = state_q;

endmodule

// File: doc/message_rx.md
Name: message_rx

Overview:
- Receive-side counterpart of the message transmitter in the RF clock domain.
- Takes demodulated baseband I samples from the AD9361 receive path and despreads them against the local P-code ROM. Code-phase alignment comes from PPS, the same alignment the transmitter uses.
- Integrates each code epoch and decides one message bit per PCODE_REPEATS epochs.
- Assembles MESSAGE_LEN-bit messages for the AXI readback path.

Parameters:
- PCODE_LEN, 40920: chips per code epoch; one chip per accepted sample.
- PCODE_REPEATS, 10: code epochs integrated per message bit.
- MESSAGE_LEN, 120: bits per message frame.
- ACC_WIDTH, 32: signed accumulator width. 12 + clog2(PCODE_LEN*PCODE_REPEATS) + 1 must be at most ACC_WIDTH; this is checked at elaboration.

Ports:
- clk  in  1  RF clock.
- rst  in  1  synchronous active-high reset.
- rx_enable  in  1  level; low forces IDLE.
- pps_in  in  1  single-cycle PPS pulse, already synchronous to clk.
- adc_valid  in  1  sample strobe; may be asserted back-to-back.
- adc_data_i  in  12  signed I sample.
- pcode_addr  out  16  P-code ROM address, registered.
- pcode_bit  in  1  ROM data, valid exactly 1 clk after pcode_addr changes.
- bit_valid  out  1  one-cycle pulse per decided bit.
- bit_value  out  1  decided bit.
- corr_value  out  ACC_WIDTH  signed integrated correlation for the last decided bit.
- msg_valid  out  1  one-cycle pulse when a full message is assembled.
- msg_data  out  MESSAGE_LEN  last full message, first received bit in the MSB.
- pps_misalign  out  1  sticky flag; cleared by rst or by a rising rx_enable.
- rx_state  out  2  current state, for debug.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters and accumulators 0.
- States:
  - IDLE: entered when rx_enable=0. Goes to ARMED when rx_enable=1.
  - ARMED: clears the counters. Goes to RUN on pps_in.
  - RUN: integrates. Goes to IDLE when rx_enable=0, from any state, on the next clock.
- pps_in and adc_valid in the same cycle while ARMED: that sample is chip 0 of epoch 0 of bit 0.
- Pipeline, three stages, with a fixed sample-to-accumulate latency of 2 clk:
  - S0: on an accepted adc_valid in RUN, pcode_addr <= chip_ctr and the sample is registered.
  - S1: the sample is delayed one stage to meet the ROM.
  - S2: pcode_bit=1 maps to +sample and 0 maps to -sample. The result is sign-extended to ACC_WIDTH and added to epoch_acc.
- Counters:
  - chip_ctr counts 0..PCODE_LEN-1 and wraps to 0.
  - epoch_ctr counts 0..PCODE_REPEATS-1.
  - bit_ctr counts 0..MESSAGE_LEN-1.
- At the last chip of an epoch: epoch_acc is added into bit_acc and epoch_acc is restarted with the next product; it is not cleared to 0 first.
- At the last epoch of a bit, one cycle after the final S2 add:
  - corr_value <= bit_acc.
  - bit_value <= ~bit_acc[ACC_WIDTH-1], so a non-negative sum decides 1; zero decides 1.
  - bit_valid pulses.
  - The bit is shifted into the msg shift register, and bit_acc is cleared.
- At the last bit of a message: msg_data <= shift register including the new bit, msg_valid pulses in the same cycle as that bit_valid, and the next message begins immediately.
- pps_in while in RUN:
  - Aligned case: the next accepted chip would be chip 0, epoch 0, bit 0. Nothing changes.
  - Misaligned case: pps_misalign <= 1; chip/epoch/bit counters, accumulators and shift register are cleared; the in-flight S1/S2 products are discarded; no bit_valid or msg_valid is issued for the partial data.
- rx_enable low mid-message: the partial message is discarded. msg_data, corr_value and pps_misalign are held. bit_valid and msg_valid are never asserted outside RUN.
- rst mid-operation: immediate return to reset values; pipeline contents are discarded.
- adc_valid outside RUN is ignored, and pcode_addr holds its value.
- Arithmetic: two's complement throughout; no saturation needed given the elaboration check. -(-2048) = +2048 fits the ACC_WIDTH range.

Decomposition:
- Package bs_rx_pkg: rx_state enum (IDLE=0, ARMED=1, RUN=2) and a clog2-based width helper, shared with the AXI status readback.
- Sub-module pcode_correlator: S0–S2 pipeline, chip_ctr and epoch_acc, with epoch_done/epoch_sum outputs.
- message_rx keeps the FSM, epoch/bit counters, decision logic and message assembly.

Test Plan:
All scenarios use PCODE_LEN=8, PCODE_REPEATS=2, MESSAGE_LEN=4, and a ROM code of 10110010 unless stated otherwise.
1. Enable, pps, then 64 back-to-back samples equal to +100·chip(code)·(msg 1,0,1,1) -> bit_valid×4; corr_value +1600, -1600, +1600, +1600; msg_valid with msg_data=4'b1011.
2. Same stream with adc_valid on alternate cycles plus random gaps -> identical bits and msg_data=4'b1011; pcode_addr sequence 0..7 repeating.
3. Extra pps_in after 20 samples -> pps_misalign=1, no bit_valid for the partial data; next 64 samples decode 4'b1011.
4. Samples all zero -> every corr_value=0, every bit_value=1, msg_data=4'hF.
5. rx_enable low after 40 samples -> rx_state=IDLE next clk, no msg_valid, msg_data holds its previous value; re-enable then pps -> clean decode and pps_misalign cleared.
6. Samples of -2048 for all 64 chips with the ROM all ones -> corr_value=-32768 for each bit, msg_data=4'b0000, no overflow.
